// File: rtl/csi2_pkt_ctrl_if.sv
// AXI4-Stream bundle carrying 32-bit lane-merged CSI-2 words.
// Handshake: a beat moves on a rising edge where tvalid && tready are both high;
// the master holds tdata/tkeep/tstrb/tlast/tuser stable while tvalid && !tready,
// and tvalid may not be withdrawn before the beat is taken.
interface axi4_stream_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/csi2_pkt_ctrl.sv
// CSI-2 packet controller: decodes header words, forwards the payload of
// matching long packets with the CRC stripped, raises frame/line pulses and
// keeps frame/line counters. All other traffic is discarded.
module csi2_pkt_ctrl #(
  parameter logic [1:0] VC        = 2'd0,
  parameter logic [5:0] DATA_TYPE = 6'h2B
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  axi4_stream_if.slave        pkt_i,
  axi4_stream_if.master       pkt_o,
  output logic                frame_start_o,
  output logic                frame_end_o,
  output logic                line_start_o,
  output logic                len_err_o,
  output logic [15:0]         frame_cnt_o,
  output logic [15:0]         line_cnt_o,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_rem;
  logic        r_o_valid;
  logic [31:0] r_o_data;
  logic [3:0]  r_o_keep;
  logic        r_o_last;
  logic        r_fs;
  logic        r_fe;
  logic        r_ls;
  logic        r_err;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_line_cnt;

  logic [5:0]  w_dt;
  logic [1:0]  w_vc;
  logic [15:0] w_wc;
  logic        w_short;
  logic        w_match;
  logic        w_out_free;
  logic        w_in_ready;
  logic        w_acc;
  logic        w_last_pay;
  logic        w_trunc;
  logic [2:0]  w_n;
  logic [3:0]  w_keep_n;
  logic [3:0]  w_keep;
  logic [31:0] w_data;
  logic        w_unused_bits;

  // Header fields; ECC byte is corrected upstream and not looked at here.
  assign w_dt    = pkt_i.tdata[5:0];
  assign w_vc    = pkt_i.tdata[7:6];
  assign w_wc    = pkt_i.tdata[23:8];
  assign w_short = (w_dt[5:4] == 2'b00);
  assign w_match = (w_vc == VC) && (w_dt == DATA_TYPE);

  // Input is only throttled while payload is being pushed into the output register.
  assign w_out_free = !r_o_valid || pkt_o.tready;
  assign w_in_ready = (r_state == S_PAY) ? w_out_free : 1'b1;
  assign w_acc      = pkt_i.tvalid && w_in_ready;
  assign pkt_i.tready = w_in_ready;

  // Payload beat sizing: at most the remaining word-count bytes are kept.
  assign w_last_pay = (r_rem <= 16'd4);
  assign w_n        = w_last_pay ? r_rem[2:0] : 3'd4;
  assign w_trunc    = pkt_i.tlast && !w_last_pay;

  // Low-n byte enables for a payload beat.
  always_comb begin
    w_keep_n = 4'b1111;
    case (w_n)
      3'd1:    w_keep_n = 4'b0001;
      3'd2:    w_keep_n = 4'b0011;
      3'd3:    w_keep_n = 4'b0111;
      default: w_keep_n = 4'b1111;
    endcase
  end

  assign w_keep = w_trunc ? pkt_i.tkeep : w_keep_n;

  // Bytes outside the kept lanes are zeroed so nothing past WC leaks out.
  always_comb begin
    w_data = '0;
    for (int b = 0; b < 4; b++) begin
      if (w_keep[b]) w_data[8*b +: 8] = pkt_i.tdata[8*b +: 8];
    end
  end

  assign w_unused_bits = ^{pkt_i.tstrb, pkt_i.tuser};

  // Packet state machine with registered output beat, pulses and counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_HDR;
      r_rem       <= '0;
      r_o_valid   <= 1'b0;
      r_o_data    <= '0;
      r_o_keep    <= '0;
      r_o_last    <= 1'b0;
      r_fs        <= 1'b0;
      r_fe        <= 1'b0;
      r_ls        <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
      r_line_cnt  <= '0;
    end else begin
      r_fs  <= 1'b0;
      r_fe  <= 1'b0;
      r_ls  <= 1'b0;
      r_err <= 1'b0;
      if (pkt_o.tready) r_o_valid <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (pkt_i.tvalid) begin
            if (w_short) begin
              if (w_vc == VC) begin
                if (w_dt == 6'h00) begin
                  r_fs        <= 1'b1;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                  r_line_cnt  <= '0;
                end else if (w_dt == 6'h01) begin
                  r_fe <= 1'b1;
                end
              end
              if (!pkt_i.tlast) begin
                r_err   <= 1'b1;
                r_state <= S_DROP;
              end
            end else if (w_match && pkt_i.tlast) begin
              r_err <= 1'b1;
            end else if (w_match && (w_wc != 16'd0)) begin
              r_ls    <= 1'b1;
              if (r_line_cnt != 16'hFFFF) r_line_cnt <= r_line_cnt + 16'd1;
              r_rem   <= w_wc;
              r_state <= S_PAY;
            end else if (!pkt_i.tlast) begin
              r_state <= S_DROP;
            end
          end
        end
        S_PAY: begin
          if (w_acc) begin
            r_o_valid <= 1'b1;
            r_o_data  <= w_data;
            r_o_keep  <= w_keep;
            r_o_last  <= w_last_pay || w_trunc;
            r_rem     <= r_rem - {13'd0, w_n};
            if (w_trunc) begin
              r_err   <= 1'b1;
              r_state <= S_HDR;
            end else if (w_last_pay) begin
              r_state <= pkt_i.tlast ? S_HDR : S_DROP;
            end
          end
        end
        S_DROP: begin
          if (pkt_i.tvalid && pkt_i.tlast) r_state <= S_HDR;
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

  assign pkt_o.tvalid  = r_o_valid;
  assign pkt_o.tdata   = r_o_data;
  assign pkt_o.tkeep   = r_o_keep;
  assign pkt_o.tstrb   = r_o_keep;
  assign pkt_o.tlast   = r_o_last;
  assign pkt_o.tuser   = 1'b0;
  assign frame_start_o = r_fs;
  assign frame_end_o   = r_fe;
  assign line_start_o  = r_ls;
  assign len_err_o     = r_err;
  assign frame_cnt_o   = r_frame_cnt;
  assign line_cnt_o    = r_line_cnt;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// Bench for csi2_pkt_ctrl: directed packets plus a randomized packet mix,
// checked against a packet-level model and an expected output-beat queue.
`timescale 1ns/1ps
module tb_csi2_pkt_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi4_stream_if in_if ();
  axi4_stream_if out_if ();

  logic        fs, fe, ls, lerr;
  logic [15:0] fcnt, lcnt;
  logic [1:0]  dbg_state;

  csi2_pkt_ctrl #(.VC(2'd0), .DATA_TYPE(6'h2B)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pkt_i         (in_if),
    .pkt_o         (out_if),
    .frame_start_o (fs),
    .frame_end_o   (fe),
    .line_start_o  (ls),
    .len_err_o     (lerr),
    .frame_cnt_o   (fcnt),
    .line_cnt_o    (lcnt),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];   // {tlast, tkeep, masked tdata}

  int fs_seen = 0, fe_seen = 0, ls_seen = 0, err_seen = 0;
  int fs_exp  = 0, fe_exp  = 0, ls_exp  = 0, err_exp  = 0;
  int fcnt_m  = 0, lcnt_m  = 0;
  logic bp_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [3:0] keep_of(input int n);
    logic [3:0] r;
    if (n >= 4) r = 4'hF;
    else r = 4'((1 << n) - 1);
    return r;
  endfunction

  // ---------------- output backpressure ----------------
  always @(posedge clk) begin
    #1;
    if (bp_en) out_if.tready = ($urandom_range(0, 2) != 0);
    else       out_if.tready = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [36:0] mon_e;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (fs)   fs_seen++;
      if (fe)   fe_seen++;
      if (ls)   ls_seen++;
      if (lerr) err_seen++;
      if (prev_stall)
        chk("hold_stable", {out_if.tvalid, out_if.tlast, out_if.tkeep, out_if.tdata},
            {1'b1, prev_beat});
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_beat  = {out_if.tlast, out_if.tkeep, out_if.tdata};
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {out_if.tlast, out_if.tkeep, out_if.tdata}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_keep", out_if.tkeep, mon_e[35:32]);
          chk("beat_last", out_if.tlast, mon_e[36]);
          chk("beat_data", out_if.tdata & bmask(mon_e[35:32]), mon_e[31:0]);
          chk("beat_strb_user", {out_if.tstrb, out_if.tuser}, {out_if.tkeep, 1'b0});
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    in_if.tvalid = 1'b1;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tstrb  = k;
    in_if.tlast  = l;
    t = 0;
    @(negedge clk);
    while (!in_if.tready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!in_if.tready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Sends one packet (header + nb further beats, tlast on the final one) and
  // applies the packet-level rules to the model as it goes.
  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input int nb,
                          input logic [3:0] last_keep);
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic        fwd, done;
    logic [31:0] d;
    logic [3:0]  k;
    int          remb;
    vc = di[7:6];
    dt = di[5:0];
    fwd = 1'b0;
    if (dt < 6'h10) begin
      if (vc == 2'd0 && dt == 6'h00) begin
        fs_exp++; fcnt_m = (fcnt_m + 1) % 65536; lcnt_m = 0;
      end
      if (vc == 2'd0 && dt == 6'h01) fe_exp++;
      if (nb > 0) err_exp++;
    end else if (vc == 2'd0 && dt == 6'h2B) begin
      if (nb == 0) err_exp++;
      else if (wc != 0) begin
        fwd = 1'b1; ls_exp++;
        if (lcnt_m < 65535) lcnt_m++;
      end
    end
    send_beat({8'($urandom), wc, di}, 4'hF, nb == 0);
    done = 1'b0;
    for (int i = 0; i < nb; i++) begin
      d = $urandom;
      k = (i == nb - 1) ? last_keep : 4'hF;
      remb = int'(wc) - 4 * i;
      if (fwd && !done) begin
        if (remb <= 4) begin
          exp_q.push_back({1'b1, keep_of(remb), d & bmask(keep_of(remb))});
          done = 1'b1;
        end else if (i == nb - 1) begin
          exp_q.push_back({1'b1, k, d & bmask(k)});
          err_exp++;
          done = 1'b1;
        end else begin
          exp_q.push_back({1'b0, 4'hF, d});
        end
      end
      send_beat(d, k, i == nb - 1);
    end
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk({tag, "_drain_timeout"}, exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_frame_start"}, fs_seen, fs_exp);
    chk({tag, "_frame_end"},   fe_seen, fe_exp);
    chk({tag, "_line_start"},  ls_seen, ls_exp);
    chk({tag, "_len_err"},     err_seen, err_exp);
    chk({tag, "_frame_cnt"},   fcnt, 16'(fcnt_m));
    chk({tag, "_line_cnt"},    lcnt, 16'(lcnt_m));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  di_tab [8];
    logic [7:0]  di;
    logic [15:0] wc;
    int          nb, nat;
    logic [3:0]  lk;

    di_tab[0] = 8'h00; di_tab[1] = 8'h01; di_tab[2] = 8'h2B; di_tab[3] = 8'h2B;
    di_tab[4] = 8'h2B; di_tab[5] = 8'h6B; di_tab[6] = 8'h2A; di_tab[7] = 8'h05;

    rst_n = 1'b0;
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0;
    in_if.tstrb = '0; in_if.tlast = 1'b0; in_if.tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", out_if.tvalid, 0);
    chk("rst_tdata_keep_last", {out_if.tdata, out_if.tkeep, out_if.tlast}, 0);
    chk("rst_pulses", {fs, fe, ls, lerr}, 0);
    chk("rst_counters", {fcnt, lcnt}, 0);
    chk("rst_in_ready", in_if.tready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame: FS, two RAW10 lines of 10 bytes, FE.
    send_pkt(8'h00, 16'd0, 0, 4'hF);
    send_pkt(8'h2B, 16'd10, 3, 4'hF);
    send_pkt(8'h2B, 16'd10, 3, 4'hF);
    send_pkt(8'h01, 16'd0, 0, 4'hF);
    drain_and_check("frame_basic");

    // CRC in a separate beat, then a following packet still decodes.
    send_pkt(8'h2B, 16'd8, 3, 4'b0011);
    send_pkt(8'h2B, 16'd4, 2, 4'b0011);
    drain_and_check("crc_split");

    // Wrong VC and wrong DT are dropped silently.
    send_pkt(8'h6B, 16'd10, 3, 4'hF);
    send_pkt(8'h2A, 16'd10, 3, 4'hF);
    drain_and_check("filtered");

    // Truncated packet, then FS still counted.
    send_pkt(8'h2B, 16'd20, 3, 4'((($urandom_range(1, 15)))));
    send_pkt(8'h00, 16'd0, 0, 4'hF);
    drain_and_check("truncated");

    // Header with tlast on a matching long packet; short packet without tlast.
    send_pkt(8'h2B, 16'd12, 0, 4'hF);
    send_pkt(8'h00, 16'd0, 1, 4'hF);
    send_pkt(8'h2B, 16'd5, 2, 4'b0111);
    drain_and_check("len_errors");

    // Long line under random output backpressure.
    bp_en = 1'b1;
    send_pkt(8'h2B, 16'd4000, 1001, 4'b0011);
    drain_and_check("long_bp");

    // Random packet mix with backpressure.
    for (int p = 0; p < 40; p++) begin
      di = di_tab[$urandom_range(0, 7)];
      if (di[5:0] < 6'h10) begin
        wc = 16'($urandom_range(0, 100));
        nb = ($urandom_range(0, 5) == 0) ? 1 : 0;
        lk = 4'hF;
      end else begin
        wc  = 16'($urandom_range(0, 30));
        nat = (int'(wc) + 2 + 3) / 4;
        lk  = keep_of(((int'(wc) + 2) % 4 == 0) ? 4 : (int'(wc) + 2) % 4);
        if ($urandom_range(0, 3) == 0) begin
          nb = $urandom_range(0, nat);
          lk = 4'($urandom_range(1, 15));
        end else begin
          nb = nat;
        end
      end
      send_pkt(di, wc, nb, lk);
    end
    drain_and_check("random_mix");
    bp_en = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a payload.
    send_beat({8'h00, 16'd40, 8'h2B}, 4'hF, 1'b0);
    ls_exp++;
    if (lcnt_m < 65535) lcnt_m++;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] d;
      d = $urandom;
      exp_q.push_back({1'b0, 4'hF, d});
      send_beat(d, 4'hF, 1'b0);
    end
    rst_n = 1'b0;
    in_if.tvalid = 1'b0;
    #1;
    chk("midrst_tvalid", out_if.tvalid, 0);
    chk("midrst_tdata_keep_last", {out_if.tdata, out_if.tkeep, out_if.tlast}, 0);
    chk("midrst_pulses", {fs, fe, ls, lerr}, 0);
    chk("midrst_counters", {fcnt, lcnt}, 0);
    exp_q.delete();
    fcnt_m = 0;
    lcnt_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(8'h00, 16'd0, 0, 4'hF);
    send_pkt(8'h2B, 16'd10, 3, 4'hF);
    drain_and_check("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csi2_pkt_ctrl.md
# csi2_pkt_ctrl

Packet-level controller between the lane aligner and the RAW10 pixel serializer in the CSI-2 receive path. It parses the 32-bit header word of each CSI-2 packet and turns frame-start short packets into the frame-start pulse the serializer needs. Long packets matching the configured virtual channel and data type have their payload forwarded byte-exact, with the CRC footer stripped and `tlast` on the last payload byte. All other traffic is discarded, and frame and line statistics are maintained.

## Interface
- `VC`, 2'd0, virtual channel to accept.
- `DATA_TYPE`, 6'h2B, long-packet data type to forward (RAW10).
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `pkt_i`  axi4_stream_if.slave  32-bit tdata, 4-bit tkeep  lane-merged byte stream; byte 0 in `tdata[7:0]`; `tlast` marks end of packet on the lanes.
- `pkt_o`  axi4_stream_if.master  32-bit tdata, 4-bit tkeep  payload bytes of accepted long packets; `tstrb` tied to `tkeep`; `tuser` tied 0.
- `frame_start_o`  out  1  one-cycle pulse on Frame Start (DT 0x00) for `VC`.
- `frame_end_o`  out  1  one-cycle pulse on Frame End (DT 0x01) for `VC`.
- `line_start_o`  out  1  one-cycle pulse when an accepted long-packet header is consumed.
- `len_err_o`  out  1  one-cycle pulse on a length violation.
- `frame_cnt_o`  out  16  Frame Start count; wraps.
- `line_cnt_o`  out  16  accepted long packets since the last Frame Start; saturates at 16'hFFFF.

## Operation
- Header word layout:
  - `DI = tdata[7:0]` = {VC[7:6], DT[5:0]}.
  - `WC = tdata[23:8]`, in bytes.
  - ECC in `tdata[31:24]` is ignored; correction is done upstream.
- DT 0x00–0x0F are short packets; all others are long packets.
- States:
  - **HDR** (reset state): `pkt_i.tready`=1. Each accepted beat is a header.
    - Short packet with matching VC: FS → `frame_start_o`, `frame_cnt`+1, `line_cnt`←0. FE → `frame_end_o`. Other short DTs are ignored.
    - Short packet without `tlast`: `len_err_o`, go to DROP.
    - Long packet with VC=`VC`, DT=`DATA_TYPE`, WC≠0 and no `tlast`: `line_start_o`, `line_cnt`+1 (saturating), `rem`←WC, go to PAY.
    - Matching long packet with `tlast` on the header beat: `len_err_o`, stay in HDR.
    - Any other long packet: go to DROP if no `tlast`, else stay in HDR.
  - **PAY**: forwards words.
    - `pkt_i.tready = !pkt_o.tvalid || pkt_o.tready`.
    - Per accepted beat: `n = min(rem,4)`; `pkt_o.tkeep` = low `n` bits set; `rem -= n`.
    - `n==rem` (last payload beat): `pkt_o.tlast`=1. Next state is HDR if `pkt_i.tlast` is on this beat, else DROP (CRC bytes).
    - `pkt_i.tlast` with `rem>4` (truncated packet): output the beat with `tlast`=1 and `tkeep`=`pkt_i.tkeep`, pulse `len_err_o`, go to HDR.
  - **DROP**: `tready`=1; discard beats; `pkt_i.tlast` → HDR.
- `rem` is 16 bits and never underflows. Bytes beyond WC in a beat are never forwarded.

## Timing
- `pkt_o` is registered: 1-cycle latency from `pkt_i` acceptance.
- `pkt_o` holds `tdata`/`tkeep`/`tlast` stable while `tvalid && !tready`.
- Full throughput: one beat per cycle when `pkt_o.tready`=1.
- Pulse outputs and counters update in the cycle after the header beat is accepted.
- `frame_start_o` is asserted at least 1 cycle before the first `pkt_o.tvalid` of that frame.
- Reset values:
  - All `pkt_o` signals 0.
  - All pulse outputs 0.
  - Counters 0.
  - State HDR.
- Reset mid-packet aborts immediately. The first post-reset beat is treated as a header.
- `pkt_o.tready` low in HDR/DROP has no effect on input acceptance. The output register still drains normally.

## Test plan
- FS (DI 0x00) short packet, then 2 long packets of DI 0x2B, WC=10, followed by FE → 2 `line_start_o` pulses; `frame_cnt_o`=1; `line_cnt_o`=2; each packet emits 3 beats with tkeep 1111, 1111, 0011; tlast only on the 3rd beat; CRC bytes never appear.
- Long packet WC=8 whose 2 CRC bytes arrive in a separate beat with `tlast` → 2 output beats with tkeep 1111; tlast on beat 2; CRC beat dropped; next header parsed correctly.
- Long packet DI 0x6B (VC=1) and DI 0x2A (RAW8) → no `pkt_o` output; `line_cnt_o` unchanged; no `len_err_o`.
- Matching packet with WC=20 and input `tlast` on the 3rd payload beat → 3 output beats; tlast on beat 3; one `len_err_o` pulse; following FS still counted.
- Random `pkt_o.tready` backpressure during a WC=4000 packet → output byte sequence identical to the unstalled run; no beat lost or duplicated.
- `rst_n_i` low for 1 cycle in mid-PAY → all outputs 0 immediately; the next beat is decoded as a header.
